gzip_block_scheduler: RTL and testbench

Sequences one compression job through the gzip core datapath on core_clock. It slices the incoming 32-bit big-endian word stream into deflate blocks of a configured size and announces each block to the encoder with its BTYPE and BFINAL. It gates the data words into the compressor, waits for the encoder to flush each block, then signals job completion. Configuration comes from the register file, already synchronised to core_clock.

---
 rtl/gzip_block_scheduler_if.sv | 21 ++
 rtl/gzip_block_scheduler.sv | 172 +++++++++++++++++
 tb/tb_gzip_block_scheduler.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gzip_block_scheduler_if.sv
// Word-stream handshake bundle used on both sides of the block scheduler.
// Master drives data/valid/keep/last, slave drives ready.
interface gzip_block_scheduler_if #(
    parameter int DW = 32
);
    logic            tvalid;
    logic            tready;
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tkeep;
    logic            tlast;

    modport master (
        output tvalid, tdata, tkeep, tlast,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast,
        output tready
    );
endinterface

// File: rtl/gzip_block_scheduler.sv
// Slices one compression job into deflate blocks, announces each block
// to the encoder and gates stream words into the compressor.
module gzip_block_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 32,
    parameter int BLK_WIDTH  = 16
) (
    input  logic                 core_clock,
    input  logic                 bus_reset,
    input  logic                 cfg_start,
    input  logic                 cfg_abort,
    input  logic [1:0]           cfg_btype,
    input  logic [LEN_WIDTH-1:0] cfg_total_bytes,
    input  logic [BLK_WIDTH-1:0] cfg_block_bytes,
    gzip_block_scheduler_if.slave  s,
    gzip_block_scheduler_if.master m,
    output logic                 blk_start,
    output logic [1:0]           blk_btype,
    output logic                 blk_final,
    input  logic                 blk_done,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic                 err_btype,
    output logic [15:0]          blk_count
);

    typedef enum logic [1:0] {
        IDLE,
        BLK_HDR,
        STREAM,
        WAIT_DONE
    } state_t;

    localparam int KW = DATA_WIDTH / 8;

    state_t               state_q;
    logic [LEN_WIDTH-1:0] tot_q;
    logic [BLK_WIDTH-1:0] blk_q;
    logic [BLK_WIDTH-1:0] eff_q;

    logic [BLK_WIDTH-1:0] eff_d;
    logic [LEN_WIDTH-1:0] hdr_tot;
    logic [BLK_WIDTH-1:0] hdr_eff;
    logic [2:0]           nbytes;
    logic [KW-1:0]        keep_d;
    logic                 in_stream;
    logic                 last_d;
    logic                 hs;

    // Block size rounded down to whole words, never zero.
    always_comb begin
        eff_d = cfg_block_bytes & ~BLK_WIDTH'(3);
        if (cfg_block_bytes == '0) begin
            eff_d = BLK_WIDTH'(65532);
        end else if (eff_d == '0) begin
            eff_d = BLK_WIDTH'(4);
        end
    end

    // Header values come from the inputs on the first block of a job.
    always_comb begin
        hdr_tot = tot_q;
        hdr_eff = eff_q;
        if (state_q == IDLE) begin
            hdr_tot = cfg_total_bytes;
            hdr_eff = eff_d;
        end
    end

    // Byte count of the current word and its keep mask / block end.
    always_comb begin
        in_stream = (state_q == STREAM);
        nbytes    = (tot_q >= LEN_WIDTH'(4)) ? 3'd4 : tot_q[2:0];
        keep_d    = '0;
        unique case (nbytes)
            3'd4:    keep_d = 4'b1111;
            3'd3:    keep_d = 4'b1110;
            3'd2:    keep_d = 4'b1100;
            3'd1:    keep_d = 4'b1000;
            default: keep_d = 4'b0000;
        endcase
        last_d = (blk_q <= BLK_WIDTH'(4)) || (tot_q <= LEN_WIDTH'(4));
        hs     = in_stream && s.tvalid && m.tready;
    end

    // Pass-through of the word stream, gated to STREAM.
    always_comb begin
        m.tvalid = in_stream && s.tvalid;
        s.tready = in_stream && m.tready;
        m.tdata  = in_stream ? s.tdata : '0;
        m.tkeep  = in_stream ? keep_d : '0;
        m.tlast  = in_stream && last_d;
    end

    // Job sequencer with registered status and block outputs.
    always_ff @(posedge core_clock or posedge bus_reset) begin
        if (bus_reset) begin
            state_q   <= IDLE;
            tot_q     <= '0;
            blk_q     <= '0;
            eff_q     <= '0;
            blk_start <= 1'b0;
            blk_btype <= 2'b00;
            blk_final <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            err_btype <= 1'b0;
            blk_count <= '0;
        end else begin
            blk_start <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            err_btype <= 1'b0;
            if (state_q != IDLE && cfg_abort) begin
                state_q <= IDLE;
                busy    <= 1'b0;
                aborted <= 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (cfg_start && !cfg_abort) begin
                            if (cfg_btype[1]) begin
                                err_btype <= 1'b1;
                            end else begin
                                blk_btype <= cfg_btype;
                                eff_q     <= eff_d;
                                tot_q     <= cfg_total_bytes;
                                blk_count <= 16'd1;
                                state_q   <= BLK_HDR;
                                busy      <= 1'b1;
                                blk_start <= 1'b1;
                                blk_final <= hdr_tot <= LEN_WIDTH'(hdr_eff);
                                blk_q     <= hdr_eff;
                            end
                        end
                    end
                    BLK_HDR: begin
                        state_q <= (tot_q == '0) ? WAIT_DONE : STREAM;
                    end
                    STREAM: begin
                        if (hs) begin
                            tot_q <= tot_q - LEN_WIDTH'(nbytes);
                            blk_q <= blk_q - BLK_WIDTH'(nbytes);
                            if (last_d) begin
                                state_q <= WAIT_DONE;
                            end
                        end
                    end
                    WAIT_DONE: begin
                        if (blk_done) begin
                            if (blk_final) begin
                                done    <= 1'b1;
                                busy    <= 1'b0;
                                state_q <= IDLE;
                            end else begin
                                blk_count <= blk_count + 16'd1;
                                state_q   <= BLK_HDR;
                                blk_start <= 1'b1;
                                blk_final <= hdr_tot <= LEN_WIDTH'(hdr_eff);
                                blk_q     <= hdr_eff;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gzip_block_scheduler.sv
// Directed bench for the gzip block scheduler: block slicing, keep masks,
// handshake stalls, abort, invalid BTYPE and asynchronous reset.
module tb_gzip_block_scheduler;

    logic        clk;
    logic        rst;
    logic        cfg_start;
    logic        cfg_abort;
    logic [1:0]  cfg_btype;
    logic [31:0] cfg_total_bytes;
    logic [15:0] cfg_block_bytes;
    logic        blk_start;
    logic [1:0]  blk_btype;
    logic        blk_final;
    logic        blk_done;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        err_btype;
    logic [15:0] blk_count;

    int errors = 0;
    int checks = 0;

    gzip_block_scheduler_if #(.DW(32)) s_if ();
    gzip_block_scheduler_if #(.DW(32)) m_if ();

    gzip_block_scheduler dut (
        .core_clock      (clk),
        .bus_reset       (rst),
        .cfg_start       (cfg_start),
        .cfg_abort       (cfg_abort),
        .cfg_btype       (cfg_btype),
        .cfg_total_bytes (cfg_total_bytes),
        .cfg_block_bytes (cfg_block_bytes),
        .s               (s_if),
        .m               (m_if),
        .blk_start       (blk_start),
        .blk_btype       (blk_btype),
        .blk_final       (blk_final),
        .blk_done        (blk_done),
        .busy            (busy),
        .done            (done),
        .aborted         (aborted),
        .err_btype       (err_btype),
        .blk_count       (blk_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one job; the bench model tracks remaining bytes per block.
    task automatic run_job(input int total, input int bsz,
                           input logic [1:0] bt, input bit stall,
                           input int abort_at, input int exp_blocks,
                           input int exp_words, input int exp_done,
                           input logic [3:0] exp_last_keep);
        int tot, brem, eff, nblk, words, dcnt, ndone, fin_cyc;
        int tail, nb;
        bit cur_final, fin, abort_sent, abort_chk;
        logic [3:0] kexp, last_keep;
        logic lexp;
        tot = total;
        eff = bsz & ~3;
        if (bsz == 0) eff = 65532;
        else if (eff == 0) eff = 4;
        brem = 0; nblk = 0; words = 0; dcnt = 0; ndone = 0;
        fin_cyc = -10; tail = 4; cur_final = 0; fin = 0;
        abort_sent = 0; abort_chk = 0; last_keep = 4'b0000;
        for (int cyc = 0; cyc < 40000 && tail > 0; cyc++) begin
            @(posedge clk);
            #1;
            cfg_start       = (cyc == 0);
            cfg_btype       = bt;
            cfg_total_bytes = total;
            cfg_block_bytes = 16'(bsz);
            cfg_abort       = 1'b0;
            s_if.tvalid = stall ? ($urandom_range(3) != 0) : 1'b1;
            m_if.tready = stall ? ($urandom_range(3) != 0) : 1'b1;
            s_if.tdata  = 32'hA500_0000 + 32'(words);
            blk_done    = (dcnt == 1);
            if (dcnt == 1 && cur_final) fin_cyc = cyc;
            if (dcnt > 0) dcnt--;
            if (abort_at >= 0 && !abort_sent && words == abort_at) begin
                cfg_abort   = 1'b1;
                s_if.tvalid = 1'b0;
                abort_sent  = 1;
            end
            @(negedge clk);
            if (abort_chk) begin
                chk("abort_pulse", 32'(aborted), 32'd1);
                chk("abort_sready", 32'(s_if.tready), 32'd0);
                chk("abort_mvalid", 32'(m_if.tvalid), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                abort_chk = 0;
                fin = 1;
            end
            if (cfg_abort) abort_chk = 1;
            if (blk_start) begin
                nblk++;
                cur_final = (tot <= eff);
                chk("blk_final", 32'(blk_final), 32'(cur_final));
                chk("blk_btype", 32'(blk_btype), 32'(bt));
                chk("blk_count", 32'(blk_count), 32'(nblk));
                brem = eff;
                if (tot == 0) dcnt = 3;
            end
            if (m_if.tvalid && m_if.tready) begin
                nb   = (tot >= 4) ? 4 : tot;
                kexp = (nb == 4) ? 4'b1111 : (nb == 3) ? 4'b1110 :
                       (nb == 2) ? 4'b1100 : 4'b1000;
                lexp = (brem <= 4) || (tot <= 4);
                chk("tdata", m_if.tdata, 32'hA500_0000 + 32'(words));
                chk("tkeep", 32'(m_if.tkeep), 32'(kexp));
                chk("tlast", 32'(m_if.tlast), 32'(lexp));
                tot  -= nb;
                brem -= nb;
                words++;
                last_keep = m_if.tkeep;
                if (lexp) dcnt = 3;
            end
            if (done) begin
                ndone++;
                chk("done_latency", 32'(cyc), 32'(fin_cyc + 1));
                fin = 1;
            end
            if (fin) tail--;
        end
        cfg_abort = 1'b0;
        chk("job_finished", 32'(fin), 32'd1);
        chk("blocks", 32'(nblk), 32'(exp_blocks));
        chk("words", 32'(words), 32'(exp_words));
        chk("done_count", 32'(ndone), 32'(exp_done));
        chk("end_blk_count", 32'(blk_count), 32'(exp_blocks));
        chk("end_busy", 32'(busy), 32'd0);
        if (exp_words > 0) chk("last_keep", 32'(last_keep),
                               32'(exp_last_keep));
    endtask

    initial begin
        rst = 1'b1;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        cfg_btype = 2'b00;
        cfg_total_bytes = '0;
        cfg_block_bytes = '0;
        blk_done = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_blk_start", 32'(blk_start), 32'd0);
        chk("rst_blk_count", 32'(blk_count), 32'd0);
        chk("rst_mvalid", 32'(m_if.tvalid), 32'd0);
        chk("rst_sready", 32'(s_if.tready), 32'd0);
        chk("rst_flags", 32'({done, aborted, err_btype, blk_final}),
            32'd0);
        rst = 1'b0;

        run_job(10, 4096, 2'b01, 0, -1, 1, 3, 1, 4'b1100);
        run_job(10000, 4096, 2'b01, 0, -1, 3, 2500, 1, 4'b1111);
        run_job(0, 4096, 2'b01, 0, -1, 1, 0, 1, 4'b0000);
        run_job(9, 6, 2'b00, 0, -1, 3, 3, 1, 4'b1000);
        run_job(65533, 0, 2'b00, 0, -1, 2, 16384, 1, 4'b1000);
        run_job(23, 8, 2'b01, 1, -1, 3, 6, 1, 4'b1110);
        run_job(40, 16, 2'b01, 1, 3, 1, 3, 0, 4'b1111);
        run_job(10, 4096, 2'b00, 0, -1, 1, 3, 1, 4'b1100);

        // Invalid BTYPE values are rejected without starting a job.
        for (int b = 2; b < 4; b++) begin
            @(posedge clk);
            #1;
            cfg_start = 1'b1;
            cfg_btype = 2'(b);
            @(posedge clk);
            #1;
            cfg_start = 1'b0;
            @(negedge clk);
            chk("err_btype", 32'(err_btype), 32'd1);
            chk("err_busy", 32'(busy), 32'd0);
            chk("err_blk_start", 32'(blk_start), 32'd0);
        end

        // Abort alongside start in IDLE: nothing happens.
        @(posedge clk);
        #1;
        cfg_btype = 2'b01;
        cfg_start = 1'b1;
        cfg_abort = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        @(negedge clk);
        chk("abort_start_busy", 32'(busy), 32'd0);
        chk("abort_start_blk", 32'(blk_start), 32'd0);
        chk("abort_idle_pulse", 32'(aborted), 32'd0);

        // Asynchronous reset in the middle of a job.
        cfg_total_bytes = 32'd40;
        cfg_block_bytes = 16'd16;
        s_if.tvalid = 1'b1;
        m_if.tready = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_mvalid", 32'(m_if.tvalid), 32'd0);
        chk("arst_blk_count", 32'(blk_count), 32'd0);
        chk("arst_flags", 32'({done, aborted}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_job(10, 4096, 2'b01, 0, -1, 1, 3, 1, 4'b1100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
